operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 174 +++++++++++++++++
 tb/tb_operand_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch
//
// Two-slot operand fetch stage between decode and execute.
//   S1 holds an instruction whose register file read is in flight (rs indices,
//      tag, and a per-operand bypass flag/data for writes that the register
//      file read cannot have seen yet).
//   S2 is the output register (resolved operands, tag, and the rs indices so
//      that later writebacks can still refresh a stalled operand).
// Whatever sits in either slot always reflects the newest architectural
// register value, because every qualifying writeback is snooped into both
// slots.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ce                  clock enable (no transfers, no state change when low)
//   i_valid/o_ready       upstream handshake, with i_rs1, i_rs2, i_tag
//   o_addr_rd_a/b         register file read addresses
//   i_dat_rd_a/b          register file read data (one cycle after address)
//   i_wb_we/addr/dat      writeback port shared with the register file
//   i_flush               drop everything in flight
//   o_valid/i_ready       downstream handshake, with o_rs1_dat, o_rs2_dat, o_tag
module operand_fetch #(
   parameter int TAG_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [4:0]       i_rs1,
   input  logic [4:0]       i_rs2,
   input  logic [TAG_W-1:0] i_tag,
   output logic [4:0]       o_addr_rd_a,
   output logic [4:0]       o_addr_rd_b,
   input  logic [31:0]      i_dat_rd_a,
   input  logic [31:0]      i_dat_rd_b,
   input  logic             i_wb_we,
   input  logic [4:0]       i_wb_addr,
   input  logic [31:0]      i_wb_dat,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_rs1_dat,
   output logic [31:0]      o_rs2_dat,
   output logic [TAG_W-1:0] o_tag
);

   logic             s1_v_reg;
   logic             s2_v_reg;
   logic [TAG_W-1:0] s1_tag_reg;
   logic [TAG_W-1:0] s2_tag_reg;

   logic advance;
   logic accept;
   logic consume;
   logic move;
   logic wb_ok;

   // Per-operand views (index 0 = rs1 / port a, index 1 = rs2 / port b)
   logic [4:0]  rs_in   [2];
   logic [31:0] rd_dat  [2];
   logic [4:0]  rd_addr [2];
   logic [31:0] s2_dat  [2];

   // advance includes i_ce: with the clock disabled S1 must keep its own
   // address on the register file so the read data stays meaningful.
   assign advance = i_ce && s1_v_reg && (!s2_v_reg || i_ready);
   assign o_ready = i_ce && !i_flush && (!s1_v_reg || advance);
   assign accept  = i_valid && o_ready;
   assign consume = i_ce && s2_v_reg && i_ready;
   assign move    = advance && !i_flush;
   // Same gating as the register file write port; x0 is never written.
   assign wb_ok   = i_ce && i_wb_we && (i_wb_addr != 5'd0);

   assign rs_in[0]  = i_rs1;
   assign rs_in[1]  = i_rs2;
   assign rd_dat[0] = i_dat_rd_a;
   assign rd_dat[1] = i_dat_rd_b;

   assign o_addr_rd_a = rd_addr[0];
   assign o_addr_rd_b = rd_addr[1];
   assign o_rs1_dat   = s2_dat[0];
   assign o_rs2_dat   = s2_dat[1];
   assign o_valid     = s2_v_reg;
   assign o_tag       = s2_tag_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic [4:0]  s1_rs_reg;
      logic        s1_byp_reg;
      logic [31:0] s1_byp_dat_reg;
      logic [4:0]  s2_rs_reg;
      logic [31:0] s2_dat_reg;

      logic        hit_in;
      logic        hit_s1;
      logic        hit_s2;
      logic [31:0] resolved;
      logic [31:0] move_dat;

      assign hit_in = wb_ok && (i_wb_addr == rs_in[gi]);
      assign hit_s1 = wb_ok && (i_wb_addr == s1_rs_reg);
      assign hit_s2 = wb_ok && (i_wb_addr == s2_rs_reg);

      // The register file read started when S1 was loaded (or was re-issued
      // while S1 stalled); any write it could not observe is in the bypass.
      assign resolved = (s1_rs_reg == 5'd0) ? 32'd0 :
                        s1_byp_reg          ? s1_byp_dat_reg : rd_dat[gi];
      // A write landing on the advance edge is newer than anything in S1.
      assign move_dat = hit_s1 ? i_wb_dat : resolved;

      assign rd_addr[gi] = (s1_v_reg && !advance) ? s1_rs_reg : rs_in[gi];
      assign s2_dat[gi]  = s2_dat_reg;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            s1_rs_reg      <= 5'd0;
            s1_byp_reg     <= 1'b0;
            s1_byp_dat_reg <= 32'd0;
            s2_rs_reg      <= 5'd0;
            s2_dat_reg     <= 32'd0;
         end else if (i_ce) begin
            if (accept) begin
               s1_rs_reg      <= rs_in[gi];
               s1_byp_reg     <= hit_in;
               s1_byp_dat_reg <= i_wb_dat;
            end else if (hit_s1) begin
               s1_byp_reg     <= 1'b1;
               s1_byp_dat_reg <= i_wb_dat;
            end

            if (move) begin
               s2_rs_reg  <= s1_rs_reg;
               s2_dat_reg <= move_dat;
            end else if (s2_v_reg && hit_s2) begin
               s2_dat_reg <= i_wb_dat;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_v_reg   <= 1'b0;
         s2_v_reg   <= 1'b0;
         s1_tag_reg <= '0;
         s2_tag_reg <= '0;
      end else if (i_ce) begin
         if (i_flush) begin
            s1_v_reg <= 1'b0;
            s2_v_reg <= 1'b0;
         end else begin
            if (accept) begin
               s1_v_reg <= 1'b1;
            end else if (advance) begin
               s1_v_reg <= 1'b0;
            end

            if (advance) begin
               s2_v_reg <= 1'b1;
            end else if (consume) begin
               s2_v_reg <= 1'b0;
            end
         end

         if (accept) begin
            s1_tag_reg <= i_tag;
         end
         if (move) begin
            s2_tag_reg <= s1_tag_reg;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//
// Drives operand_fetch together with a small behavioural register file.
// Reference model: the block is a FIFO of at most two instructions. An entry
// becomes visible at the output once it has lived through one enabled edge,
// and a visible entry's operands always equal the current architectural
// register contents. Directed vector table, hand-written back-pressure /
// flush / reset sequences, then randomized traffic.
module tb_operand_fetch;

   localparam int TAG_W = 32;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_ce;
   logic             i_valid;
   logic             o_ready;
   logic [4:0]       i_rs1;
   logic [4:0]       i_rs2;
   logic [TAG_W-1:0] i_tag;
   logic [4:0]       o_addr_rd_a;
   logic [4:0]       o_addr_rd_b;
   logic [31:0]      rd_a;
   logic [31:0]      rd_b;
   logic             i_wb_we;
   logic [4:0]       i_wb_addr;
   logic [31:0]      i_wb_dat;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [31:0]      o_rs1_dat;
   logic [31:0]      o_rs2_dat;
   logic [TAG_W-1:0] o_tag;

   always #5 i_clk = ~i_clk;

   operand_fetch #(.TAG_W(TAG_W)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ce        (i_ce),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .i_tag       (i_tag),
      .o_addr_rd_a (o_addr_rd_a),
      .o_addr_rd_b (o_addr_rd_b),
      .i_dat_rd_a  (rd_a),
      .i_dat_rd_b  (rd_b),
      .i_wb_we     (i_wb_we),
      .i_wb_addr   (i_wb_addr),
      .i_wb_dat    (i_wb_dat),
      .i_flush     (i_flush),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_rs1_dat   (o_rs1_dat),
      .o_rs2_dat   (o_rs2_dat),
      .o_tag       (o_tag)
   );

   // Register file: synchronous read returning the pre-write value, write
   // gated by the clock enable.
   logic [31:0] regs [32];

   function automatic logic [31:0] reg_val(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : regs[a];
   endfunction

   always @(posedge i_clk) begin
      if (i_ce && i_wb_we && i_wb_addr != 5'd0) regs[i_wb_addr] <= i_wb_dat;
      rd_a <= reg_val(o_addr_rd_a);
      rd_b <= reg_val(o_addr_rd_b);
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] tag;
      int          age;
   } item_t;

   item_t       q[$];
   logic [31:0] consumed[$];
   logic        acc_s;
   logic        cons_s;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Compare outputs mid-cycle against the model; remember what the edge does.
   task automatic mid_check();
      logic want_valid;
      logic want_ready;
      @(negedge i_clk);
      want_valid = (q.size() > 0) && (q[0].age >= 1);
      want_ready = i_ce && !i_flush && (q.size() < 2 || i_ready);
      check("model o_valid", {31'd0, o_valid}, {31'd0, want_valid});
      check("model o_ready", {31'd0, o_ready}, {31'd0, want_ready});
      if (want_valid) begin
         check("model o_rs1_dat", o_rs1_dat, reg_val(q[0].rs1));
         check("model o_rs2_dat", o_rs2_dat, reg_val(q[0].rs2));
         check("model o_tag", o_tag, q[0].tag);
      end
      acc_s  = i_valid && want_ready;
      cons_s = i_ce && !i_flush && want_valid && i_ready;
   endtask

   task automatic edge_update();
      @(posedge i_clk);
      if (i_rst) begin
         q.delete();
      end else if (i_ce) begin
         if (i_flush) begin
            q.delete();
         end else begin
            if (cons_s) begin
               $display("xfer tag=%0h rs1=x%0d rs2=x%0d", q[0].tag, q[0].rs1, q[0].rs2);
               consumed.push_back(q[0].tag);
               void'(q.pop_front());
            end
            foreach (q[k]) q[k].age++;
            if (acc_s) q.push_back('{rs1: i_rs1, rs2: i_rs2, tag: i_tag, age: 0});
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      i_rst = 1'b0; i_ce = 1'b1; i_valid = 1'b0; i_rs1 = 5'd0; i_rs2 = 5'd0;
      i_tag = '0; i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_dat = 32'd0;
      i_flush = 1'b0; i_ready = 1'b1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] tag;
      logic        ready;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdat;
      logic        e_valid;
      logic        e_ready;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic [31:0] e_tag;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int nxt;

      // basic read, same-edge hazard, x0 write, stall write-through
      tbl[0]  = '{1, 5, 0, 1, 1, 0, 0, 0,            0, 1, 0,            0,            0};
      tbl[1]  = '{0, 0, 0, 0, 1, 0, 0, 0,            0, 1, 0,            0,            0};
      tbl[2]  = '{1, 7, 0, 2, 1, 1, 7, 32'hDEADBEEF, 1, 1, 32'h1234,     0,            1};
      tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 0,            0, 1, 0,            0,            0};
      tbl[4]  = '{1, 0, 3, 3, 1, 1, 0, 32'hFFFFFFFF, 1, 1, 32'hDEADBEEF, 0,            2};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0,            0,            0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,            1, 1, 0,            0,            3};
      tbl[7]  = '{0, 0, 0, 0, 0, 1, 3, 32'hA5A5A5A5, 1, 1, 0,            0,            3};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,            1, 1, 0,            32'hA5A5A5A5, 3};
      tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0,            1, 1, 0,            32'hA5A5A5A5, 3};
      tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0,            0, 1, 0,            0,            0};

      // Reset while preloading the register file through the writeback port.
      idle_inputs();
      i_rst = 1'b1;
      for (int r = 0; r < 32; r++) begin
         i_wb_we   = 1'b1;
         i_wb_addr = r[4:0];
         i_wb_dat  = (r == 5) ? 32'h1234 : 32'd0;
         @(posedge i_clk);
         #1;
      end
      idle_inputs();

      @(negedge i_clk);
      check("reset o_valid", {31'd0, o_valid}, 32'd0);
      check("reset o_rs1_dat", o_rs1_dat, 32'd0);
      check("reset o_rs2_dat", o_rs2_dat, 32'd0);
      check("reset o_tag", o_tag, 32'd0);
      check("reset o_ready", {31'd0, o_ready}, 32'd1);
      @(posedge i_clk);
      #1;

      for (int v = 0; v < 11; v++) begin
         i_valid = tbl[v].valid; i_rs1 = tbl[v].rs1; i_rs2 = tbl[v].rs2;
         i_tag = tbl[v].tag; i_ready = tbl[v].ready; i_wb_we = tbl[v].we;
         i_wb_addr = tbl[v].waddr; i_wb_dat = tbl[v].wdat;
         mid_check();
         check($sformatf("vec%0d o_valid", v), {31'd0, o_valid}, {31'd0, tbl[v].e_valid});
         check($sformatf("vec%0d o_ready", v), {31'd0, o_ready}, {31'd0, tbl[v].e_ready});
         if (tbl[v].e_valid) begin
            check($sformatf("vec%0d o_rs1_dat", v), o_rs1_dat, tbl[v].e_rs1);
            check($sformatf("vec%0d o_rs2_dat", v), o_rs2_dat, tbl[v].e_rs2);
            check($sformatf("vec%0d o_tag", v), o_tag, tbl[v].e_tag);
         end
         edge_update();
      end
      idle_inputs();

      // Back-pressure: four instructions queued behind a stalled consumer.
      consumed.delete();
      nxt = 0;
      for (int c = 0; c < 16; c++) begin
         i_valid = (nxt < 4);
         i_tag   = 32'd100 + 32'(nxt);
         i_rs1   = 5'($urandom_range(0, 7));
         i_rs2   = 5'($urandom_range(0, 7));
         i_ready = (c >= 6);
         mid_check();
         if (c >= 2 && c < 6) check("bp o_ready full", {31'd0, o_ready}, 32'd0);
         if (acc_s) nxt++;
         edge_update();
      end
      check("bp consumed count", 32'(consumed.size()), 32'd4);
      for (int k = 0; k < consumed.size() && k < 4; k++)
         check($sformatf("bp order %0d", k), consumed[k], 32'd100 + 32'(k));
      idle_inputs();

      // Flush with both slots full.
      i_ready = 1'b0; i_valid = 1'b1; i_rs1 = 5'd5; i_rs2 = 5'd7;
      for (int k = 0; k < 2; k++) begin
         i_tag = 32'd200 + 32'(k);
         mid_check();
         edge_update();
      end
      i_flush = 1'b1; i_tag = 32'd202;
      mid_check();
      check("pre-flush o_valid", {31'd0, o_valid}, 32'd1);
      edge_update();
      i_flush = 1'b0; i_valid = 1'b0;
      mid_check();
      check("flush o_valid", {31'd0, o_valid}, 32'd0);
      check("flush o_ready", {31'd0, o_ready}, 32'd1);
      edge_update();

      // Reset with both slots full.
      i_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_tag = 32'd300 + 32'(k);
         mid_check();
         edge_update();
      end
      i_valid = 1'b0; i_rst = 1'b1;
      mid_check();
      check("pre-reset o_rs1_dat", o_rs1_dat, 32'h1234);
      edge_update();
      i_rst = 1'b0;
      mid_check();
      check("mid reset o_valid", {31'd0, o_valid}, 32'd0);
      check("mid reset o_rs1_dat", o_rs1_dat, 32'd0);
      check("mid reset o_rs2_dat", o_rs2_dat, 32'd0);
      check("mid reset o_tag", o_tag, 32'd0);
      edge_update();

      // Randomized traffic with small register indices to provoke hazards.
      for (int c = 0; c < 2000; c++) begin
         i_ce      = ($urandom_range(0, 9) != 0);
         i_rst     = ($urandom_range(0, 199) == 0);
         i_flush   = ($urandom_range(0, 39) == 0);
         i_valid   = ($urandom_range(0, 9) < 7);
         i_ready   = ($urandom_range(0, 9) < 6);
         i_rs1     = 5'($urandom_range(0, 7));
         i_rs2     = 5'($urandom_range(0, 7));
         i_tag     = $urandom;
         i_wb_we   = $urandom_range(0, 1) == 1;
         i_wb_addr = 5'($urandom_range(0, 7));
         i_wb_dat  = $urandom;
         mid_check();
         edge_update();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
